ise_feeder: RTL and testbench

Host-side transmitter and result collector for the image sorting engine (ISE). On a start pulse it streams IMG_NUM images of PIX_NUM 24-bit RGB pixels from a synchronous pixel memory onto the ISE's `image_in_index`/`pixel_in` inputs, honouring `busy` back-pressure. It then collects the sorted `out_valid`/`color_index`/`image_out_index` result stream and reports completion. It sits between the frame store and `ISE` at the top of the design.

---
 rtl/ise_feeder_pkg.sv | 20 ++
 rtl/ise_feed_skid.sv | 77 +++++++
 rtl/ise_feeder.sv | 143 ++++++++++++++
 tb/tb_ise_feeder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ise_feeder_pkg.sv
// ise_feeder_pkg: shared state encodings, colour codes and widths for the ISE feeder.
package ise_feeder_pkg;

    localparam int unsigned IMG_IDX_W = 5;
    localparam int unsigned PIX_W     = 24;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSend    = 2'd1,
        StWaitRes = 2'd2,
        StDone    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ColRed   = 2'd0,
        ColGreen = 2'd1,
        ColBlue  = 2'd2
    } color_e;

endpackage

// File: rtl/ise_feed_skid.sv
// ise_feed_skid: 2-entry skid buffer between a 1-cycle-latency pixel memory and the ISE.
// Tracks the single in-flight read so a busy rise never drops returning data.
module ise_feed_skid
    import ise_feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_issue,
    input  logic [IMG_IDX_W-1:0] rd_img,
    input  logic [PIX_W-1:0]     rdata,
    input  logic                 busy,
    output logic                 valid,
    output logic [PIX_W-1:0]     pixel,
    output logic [IMG_IDX_W-1:0] img,
    output logic                 xfer,
    output logic                 rd_ok
);
    localparam int unsigned EntW = IMG_IDX_W + PIX_W;

    logic [EntW-1:0]      ent_q [2];
    logic [EntW-1:0]      ent_d [2];
    logic [1:0]           cnt_q, cnt_d;
    logic                 fly_q;
    logic [IMG_IDX_W-1:0] fly_img_q;
    logic [EntW-1:0]      fly_ent, head;
    logic                 push, pop;
    logic [2:0]           level;

    assign fly_ent = {fly_img_q, rdata};
    assign pixel   = head[PIX_W-1:0];
    assign img     = head[EntW-1:PIX_W];

    // Head selection (buffer first, else bypass of returning read), flow control and next state.
    always_comb begin
        head = '0;
        if (cnt_q != 2'd0) begin
            head = ent_q[0];
        end else if (fly_q) begin
            head = fly_ent;
        end
        valid = (cnt_q != 2'd0) || fly_q;
        xfer  = valid && !busy;
        pop   = xfer && (cnt_q != 2'd0);
        // Returning data is buffered unless it went straight out through the bypass.
        push  = fly_q && !(xfer && (cnt_q == 2'd0));
        level = {1'b0, cnt_q} + {2'b0, fly_q} - {2'b0, xfer};
        rd_ok = level < 3'd2;

        ent_d = ent_q;
        cnt_d = cnt_q;
        if (pop) begin
            ent_d[0] = ent_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        if (push) begin
            ent_d[cnt_d[0]] = fly_ent;
            cnt_d           = cnt_d + 2'd1;
        end
    end

    // Buffer and in-flight state; reset discards anything still returning from memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q[0]  <= '0;
            ent_q[1]  <= '0;
            cnt_q     <= '0;
            fly_q     <= 1'b0;
            fly_img_q <= '0;
        end else begin
            ent_q     <= ent_d;
            cnt_q     <= cnt_d;
            fly_q     <= rd_issue;
            fly_img_q <= rd_img;
        end
    end

endmodule

// File: rtl/ise_feeder.sv
// ise_feeder: streams IMG_NUM x PIX_NUM RGB pixels from the frame store into the ISE,
// then collects the sorted result stream. Optional result checker: ISE_FEED_CHECK_EN.
module ise_feeder
    import ise_feeder_pkg::*;
#(
    parameter int unsigned IMG_NUM = 32,
    parameter int unsigned PIX_NUM = 16384,
    parameter int unsigned ADDR_W  = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [PIX_W-1:0]     mem_rdata,
    input  logic                 busy,
    output logic [IMG_IDX_W-1:0] image_in_index,
    output logic [PIX_W-1:0]     pixel_in,
    output logic                 pix_valid,
    input  logic                 out_valid,
    input  logic [1:0]           color_index,
    input  logic [IMG_IDX_W-1:0] image_out_index,
    output logic [5:0]           res_cnt,
    output logic                 done,
    output logic                 err
);
    localparam int unsigned       PixAw    = $clog2(PIX_NUM);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(IMG_NUM * PIX_NUM - 1);
    localparam logic [5:0]        ResMax   = 6'(IMG_NUM);

    state_e               state_q;
    logic [ADDR_W-1:0]    rd_addr_q, xf_addr_q;
    logic                 rd_done_q;
    logic [5:0]           res_cnt_q, res_cnt_d;
    logic                 start_ok, capture, xfer, rd_ok, last_xfer;
    logic [IMG_IDX_W-1:0] rd_img;

    assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
    assign capture   = out_valid && (state_q != StIdle);
    assign mem_rd    = (state_q == StSend) && !rd_done_q && rd_ok;
    assign mem_addr  = rd_addr_q;
    assign rd_img    = IMG_IDX_W'(rd_addr_q >> PixAw);
    assign last_xfer = xfer && (xf_addr_q == LastAddr);
    assign res_cnt   = res_cnt_q;
    assign done      = (state_q == StDone);

    ise_feed_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .rd_issue (mem_rd),
        .rd_img   (rd_img),
        .rdata    (mem_rdata),
        .busy     (busy),
        .valid    (pix_valid),
        .pixel    (pixel_in),
        .img      (image_in_index),
        .xfer     (xfer),
        .rd_ok    (rd_ok)
    );

    // Result counter: cleared by an accepted start, saturates at IMG_NUM.
    always_comb begin
        res_cnt_d = res_cnt_q;
        if (start_ok) begin
            res_cnt_d = '0;
        end else if (capture && (res_cnt_q != ResMax)) begin
            res_cnt_d = res_cnt_q + 6'd1;
        end
    end

    // Run FSM with read/transfer address counters; both counters wrap to 0 at run end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            rd_addr_q <= '0;
            xf_addr_q <= '0;
            rd_done_q <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
            if (mem_rd) begin
                rd_addr_q <= (rd_addr_q == LastAddr) ? '0 : rd_addr_q + 1'b1;
                rd_done_q <= (rd_addr_q == LastAddr);
            end
            if (xfer) begin
                xf_addr_q <= last_xfer ? '0 : xf_addr_q + 1'b1;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        state_q   <= StSend;
                        rd_done_q <= 1'b0;
                    end
                end
                StSend: begin
                    if (last_xfer) begin
                        state_q <= (res_cnt_d == ResMax) ? StDone : StWaitRes;
                    end
                end
                StWaitRes: begin
                    if (res_cnt_d == ResMax) begin
                        state_q <= StDone;
                    end
                end
            endcase
        end
    end

`ifdef ISE_FEED_CHECK_EN
    logic [31:0] seen_q;
    logic [1:0]  prev_col_q;
    logic        err_q;
    logic        bad;

    assign bad = (color_index > ColBlue) || (color_index < prev_col_q) ||
                 seen_q[image_out_index] || (res_cnt_q == ResMax);
    assign err = err_q;

    // Sticky result checker; history is cleared by an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_q     <= '0;
            prev_col_q <= ColRed;
            err_q      <= 1'b0;
        end else if (start_ok) begin
            seen_q     <= '0;
            prev_col_q <= ColRed;
            err_q      <= 1'b0;
        end else if (capture) begin
            if (bad) begin
                err_q <= 1'b1;
            end
            seen_q[image_out_index] <= 1'b1;
            prev_col_q              <= color_index;
        end
    end
`else
    logic unused_res;
    assign unused_res = ^{color_index, image_out_index};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_ise_feeder.sv
// tb_ise_feeder: directed bench for ise_feeder with IMG_NUM=2, PIX_NUM=4.
module tb_ise_feeder;
    import ise_feeder_pkg::*;

`ifdef ISE_FEED_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, busy, out_valid;
    logic        mem_rd, pix_valid, done, err;
    logic [2:0]  mem_addr;
    logic [23:0] mem_rdata, pixel_in;
    logic [4:0]  image_in_index, image_out_index;
    logic [1:0]  color_index;
    logic [5:0]  res_cnt;

    logic [23:0] mem_tbl [8] = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0,
                                 24'hD0E0F0, 24'h0F1E2D, 24'h3C4B5A, 24'h697887};
    logic [4:0]  exp_img [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1};

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rd_count = 0;
    logic [23:0] log_pix [$];
    logic [4:0]  log_img [$];
    int          log_cyc [$];

    ise_feeder #(
        .IMG_NUM (2),
        .PIX_NUM (4),
        .ADDR_W  (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .image_in_index  (image_in_index),
        .pixel_in        (pixel_in),
        .pix_valid       (pix_valid),
        .out_valid       (out_valid),
        .color_index     (color_index),
        .image_out_index (image_out_index),
        .res_cnt         (res_cnt),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Synchronous pixel memory, one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_tbl[mem_addr];
    end

    // Transfer and read monitor.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (pix_valid && !busy) begin
            log_pix.push_back(pixel_in);
            log_img.push_back(image_in_index);
            log_cyc.push_back(cyc);
        end
        if (mem_rd) rd_count = rd_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic clear_log();
        log_pix.delete();
        log_img.delete();
        log_cyc.delete();
        rd_count = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic give_result(input logic [1:0] col, input logic [4:0] idx);
        out_valid       = 1'b1;
        color_index     = col;
        image_out_index = idx;
        step();
        out_valid = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int n);
        int k = 0;
        while (log_pix.size() < n && k < 200) begin
            step();
            k++;
        end
        check({tag, "_wait"}, log_pix.size(), n);
    endtask

    task automatic verify_log(input string tag, input bit consecutive);
        check({tag, "_n"}, log_pix.size(), 8);
        for (int i = 0; i < 8 && i < log_pix.size(); i++) begin
            check({tag, "_pix"}, log_pix[i], mem_tbl[i]);
            check({tag, "_img"}, log_img[i], exp_img[i]);
            if (consecutive) check({tag, "_cyc"}, log_cyc[i] - log_cyc[0], i);
        end
        check({tag, "_rd"}, rd_count, 8);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; busy = 1'b0; out_valid = 1'b0;
        color_index = 2'd0; image_out_index = 5'd0;
        step();
        neg();
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_img", image_in_index, 0);
        check("rst_pixel", pixel_in, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_res_cnt", res_cnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        step();
        reset = 1'b1;
        step();

        // Run 1: no back-pressure.
        clear_log();
        pulse_start();
        neg();
        check("r1_mem_rd", mem_rd, 1);
        check("r1_addr0", mem_addr, 0);
        check("r1_pv_early", pix_valid, 0);
        step();
        neg();
        check("r1_pv_first", pix_valid, 1);
        check("r1_pix_first", pixel_in, mem_tbl[0]);
        wait_log("r1", 8);
        neg();
        check("r1_wr_mem_rd", mem_rd, 0);
        check("r1_wr_pv", pix_valid, 0);
        step();
        verify_log("r1", 1'b1);
        give_result(2'd0, 5'd1);
        neg();
        check("r1_res1", res_cnt, 1);
        check("r1_done_early", done, 0);
        give_result(2'd2, 5'd0);
        neg();
        check("r1_res2", res_cnt, 2);
        check("r1_done", done, 1);
        check("r1_err", err, 0);
        step();

        // Run 2: busy held for 3 cycles while pixel 2 is presented.
        clear_log();
        pulse_start();
        neg();
        check("r2_done_clr", done, 0);
        check("r2_res_clr", res_cnt, 0);
        step();
        step();
        step();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            neg();
            check("r2_hold_pix", pixel_in, mem_tbl[2]);
            check("r2_hold_img", image_in_index, 0);
            check("r2_hold_pv", pix_valid, 1);
            step();
        end
        busy = 1'b0;
        check("r2_before", log_pix.size(), 2);
        neg();
        check("r2_resume", pixel_in, mem_tbl[2]);
        wait_log("r2", 8);
        step();
        verify_log("r2", 1'b0);
        give_result(2'd0, 5'd0);
        give_result(2'd1, 5'd1);
        neg();
        check("r2_done", done, 1);
        check("r2_err", err, 0);
        give_result(2'd2, 5'd1);
        neg();
        check("r2_sat", res_cnt, 2);
        check("r2_err_extra", err, CHK);
        step();

        // Run 3: busy toggling every cycle.
        clear_log();
        pulse_start();
        neg();
        check("r3_err_clr", err, 0);
        begin
            int k = 0;
            while (log_pix.size() < 8 && k < 100) begin
                busy = ~busy;
                step();
                k++;
            end
        end
        busy = 1'b0;
        step();
        step();
        verify_log("r3", 1'b0);
        give_result(2'd2, 5'd0);
        give_result(2'd1, 5'd1);
        neg();
        check("r3_res", res_cnt, 2);
        check("r3_done", done, 1);
        check("r3_err_dec", err, CHK);
        step();

        // Run 4: start pulsed mid-SEND is ignored.
        clear_log();
        pulse_start();
        step();
        step();
        pulse_start();
        wait_log("r4", 8);
        step();
        verify_log("r4", 1'b1);
        check("r4_res", res_cnt, 0);
        check("r4_done", done, 0);

        // Run 5: reset asserted mid-SEND.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        clear_log();
        pulse_start();
        step();
        step();
        reset = 1'b0;
        neg();
        check("r5_mem_rd", mem_rd, 0);
        check("r5_addr", mem_addr, 0);
        check("r5_img", image_in_index, 0);
        check("r5_pix", pixel_in, 0);
        check("r5_pv", pix_valid, 0);
        check("r5_res", res_cnt, 0);
        check("r5_done", done, 0);
        check("r5_err", err, 0);
        step();
        reset = 1'b1;
        neg();
        check("r5_discard", pix_valid, 0);
        give_result(2'd1, 5'd0);
        neg();
        check("r5_idle_res", res_cnt, 0);
        step();

        // Run 6: restart from address 0.
        clear_log();
        pulse_start();
        neg();
        check("r6_mem_rd", mem_rd, 1);
        check("r6_addr0", mem_addr, 0);
        wait_log("r6", 8);
        step();
        verify_log("r6", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
